reg_wb_queue: RTL and testbench

//  Writeback initiator for the register file write port (we/waddr/wdata).

---
 rtl/reg_wb_queue_pkg.sv | 20 ++
 rtl/reg_wb_queue_if.sv | 46 ++++
 rtl/reg_wb_queue_fifo.sv | 55 +++++
 rtl/reg_wb_queue.sv | 107 ++++++++++
 tb/tb_reg_wb_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_queue_pkg.sv
// reg_wb_queue_pkg: shared widths, encodings and entry type for the writeback queue
//   REG_W / RADDR_W : register data / address widths
//   WBQ_DEPTH       : default FIFO depth
//   RST_ENABLE      : reset level (active-low)
//   wb_ent_t        : one pending regfile write {addr, data}
package reg_wb_queue_pkg;
    localparam int REG_W = 32;
    localparam int RADDR_W = 5;
    localparam int WBQ_DEPTH = 4;
    localparam logic RST_ENABLE = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;
    typedef logic [REG_W-1:0] reg_t;
    typedef logic [RADDR_W-1:0] raddr_t;
    typedef struct packed {
        raddr_t addr;
        reg_t   data;
    } wb_ent_t;
endpackage

// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if: producer handshakes, regfile write port and status of the writeback queue
//   alu_* / mem_* : valid/ready result channels from ALU and load unit
//   we/waddr/wdata: registered regfile write port
//   count/empty   : FIFO occupancy
//   byp_*         : bypass lookup, present only with WBQ_BYPASS_EN
//   slave modport : the queue; master modport: its environment
interface reg_wb_queue_if #(
    parameter int DEPTH = reg_wb_queue_pkg::WBQ_DEPTH
);
    import reg_wb_queue_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic             alu_valid;
    logic             alu_ready;
    raddr_t           alu_waddr;
    reg_t             alu_wdata;
    logic             mem_valid;
    logic             mem_ready;
    raddr_t           mem_waddr;
    reg_t             mem_wdata;
    logic             we;
    raddr_t           waddr;
    reg_t             wdata;
    logic [CNT_W-1:0] count;
    logic             empty;
`ifdef WBQ_BYPASS_EN
    raddr_t           byp_raddr;
    logic             byp_hit;
    reg_t             byp_data;
`endif
    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
`ifdef WBQ_BYPASS_EN
        input  byp_raddr,
        output byp_hit, byp_data,
`endif
        output alu_ready, mem_ready, we, waddr, wdata, count, empty
    );
    modport master (
        output alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
`ifdef WBQ_BYPASS_EN
        output byp_raddr,
        input  byp_hit, byp_data,
`endif
        input  alu_ready, mem_ready, we, waddr, wdata, count, empty
    );
endinterface

// File: rtl/reg_wb_queue_fifo.sv
// reg_wb_queue_fifo: in-order entry store with up to two pushes and one pop per cycle
//   clk, rst        : clock, synchronous active-low reset
//   i_push0/i_ent0  : first (older) entry pushed this cycle
//   i_push1/i_ent1  : second entry, only together with i_push0
//   i_pop           : remove head
//   o_head/o_count  : head entry and occupancy
//   o_ents/o_rd_ptr : raw storage and read pointer for bypass lookup (WBQ_BYPASS_EN only)
module reg_wb_queue_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push0,
    input  wb_ent_t          i_ent0,
    input  logic             i_push1,
    input  wb_ent_t          i_ent1,
    input  logic             i_pop,
`ifdef WBQ_BYPASS_EN
    output wb_ent_t          o_ents [DEPTH],
    output logic [PTR_W-1:0] o_rd_ptr,
`endif
    output wb_ent_t          o_head,
    output logic [CNT_W-1:0] o_count
);
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    wb_ent_t          r_mem [DEPTH];

    // Storage is not cleared on reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push0) r_mem[r_wr] <= i_ent0;
            if (i_push1) r_mem[r_wr + PTR_W'(1)] <= i_ent1;
            r_wr  <= r_wr + PTR_W'(i_push0) + PTR_W'(i_push1);
            r_rd  <= r_rd + PTR_W'(i_pop);
            r_cnt <= r_cnt + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
`ifdef WBQ_BYPASS_EN
    assign o_ents   = r_mem;
    assign o_rd_ptr = r_rd;
`endif
endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue retiring ALU/load results to the regfile, one per cycle
//   clk  : clock, all state on posedge
//   rst  : synchronous reset, active-low
//   bus  : reg_wb_queue_if.slave - ALU/load valid/ready channels, registered we/waddr/wdata,
//          count/empty, and byp_raddr/byp_hit/byp_data when WBQ_BYPASS_EN is defined
//   Macro WBQ_BYPASS_EN: enables combinational youngest-match bypass lookup.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    reg_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_M2 = CNT_W'(DEPTH - 2);

    logic [CNT_W-1:0] w_cnt;
    logic             w_alu_rdy;
    logic             w_mem_rdy;
    logic             w_alu_push;
    logic             w_mem_push;
    logic             w_pop;
    wb_ent_t          w_alu_ent;
    wb_ent_t          w_mem_ent;
    wb_ent_t          w_ent0;
    wb_ent_t          w_head;
    logic             r_we;
    wb_ent_t          r_ent;
`ifdef WBQ_BYPASS_EN
    wb_ent_t          w_ents [DEPTH];
    logic [PTR_W-1:0] w_rd_ptr;
`endif

    // Readiness looks only at the start-of-cycle count, so a same-cycle pop never
    // frees a slot; with one slot left the ALU has priority over the load unit.
    always_comb begin
        w_alu_rdy  = w_cnt <= C_M1;
        w_mem_rdy  = (w_cnt <= C_M2) || (w_cnt == C_M1 && !bus.alu_valid);
        // r0 writes complete the handshake but are dropped here.
        w_alu_push = bus.alu_valid && w_alu_rdy && bus.alu_waddr != '0;
        w_mem_push = bus.mem_valid && w_mem_rdy && bus.mem_waddr != '0;
        w_pop      = w_cnt != '0;
        w_alu_ent  = '{addr: bus.alu_waddr, data: bus.alu_wdata};
        w_mem_ent  = '{addr: bus.mem_waddr, data: bus.mem_wdata};
        // The load result is treated as older, so it takes the first slot.
        w_ent0     = w_mem_push ? w_mem_ent : w_alu_ent;
    end

    reg_wb_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push0  (w_mem_push || w_alu_push),
        .i_ent0   (w_ent0),
        .i_push1  (w_mem_push && w_alu_push),
        .i_ent1   (w_alu_ent),
        .i_pop    (w_pop),
`ifdef WBQ_BYPASS_EN
        .o_ents   (w_ents),
        .o_rd_ptr (w_rd_ptr),
`endif
        .o_head   (w_head),
        .o_count  (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_we  <= WRITE_DISABLE;
            r_ent <= '0;
        end else begin
            r_we  <= w_pop ? WRITE_ENABLE : WRITE_DISABLE;
            r_ent <= w_pop ? w_head : '0;
        end
    end

    assign bus.alu_ready = w_alu_rdy;
    assign bus.mem_ready = w_mem_rdy;
    assign bus.we        = r_we;
    assign bus.waddr     = r_ent.addr;
    assign bus.wdata     = r_ent.data;
    assign bus.count     = w_cnt;
    assign bus.empty     = w_cnt == '0;

`ifdef WBQ_BYPASS_EN
    // Scan oldest to youngest (output register first, then FIFO from the head)
    // so the last match found is the youngest.
    always_comb begin
        bus.byp_hit  = 1'b0;
        bus.byp_data = ZERO_WORD;
        if (bus.byp_raddr != '0) begin
            if (r_we && r_ent.addr == bus.byp_raddr) begin
                bus.byp_hit  = 1'b1;
                bus.byp_data = r_ent.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < w_cnt && w_ents[w_rd_ptr + PTR_W'(i)].addr == bus.byp_raddr) begin
                    bus.byp_hit  = 1'b1;
                    bus.byp_data = w_ents[w_rd_ptr + PTR_W'(i)].data;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: self-checking bench for reg_wb_queue with a write-order scoreboard
module tb_reg_wb_queue;
    import reg_wb_queue_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   m_cnt = 0;
    logic mon_en = 1'b0;
    wb_ent_t sb [$];

    reg_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every observed write must be the oldest expected one; idle cycles must be all zero.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (bus.we === 1'b1) begin
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got waddr=%0d wdata=%h, required no write", bus.waddr, bus.wdata);
                end else begin
                    wb_ent_t e;
                    e = sb.pop_front();
                    if (bus.waddr !== e.addr || bus.wdata !== e.data) begin
                        bad++;
                        $display("FAIL wb_order: got r%0d=%h, required r%0d=%h", bus.waddr, bus.wdata, e.addr, e.data);
                    end
                end
            end else if (bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0) begin
                bad++;
                $display("FAIL wb_idle: got we=%b waddr=%0d wdata=%h, required 0/0/0", bus.we, bus.waddr, bus.wdata);
            end
        end
    end

    // One cycle: drive inputs, check readiness/count against the model at negedge,
    // push accepted non-r0 entries (load first), advance model, return at posedge+1.
    task automatic step(input logic av, input raddr_t aa, input reg_t ad,
                        input logic mv, input raddr_t ma, input reg_t md);
        logic ear, emr;
        int   np;
        bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wdata = ad;
        bus.mem_valid = mv; bus.mem_waddr = ma; bus.mem_wdata = md;
        @(negedge clk);
        ear = m_cnt <= DEPTH - 1;
        emr = (m_cnt <= DEPTH - 2) || (m_cnt == DEPTH - 1 && !av);
        total += 4;
        if (bus.alu_ready !== ear) begin bad++; $display("FAIL alu_ready: got %b, required %b (cnt %0d)", bus.alu_ready, ear, m_cnt); end
        if (bus.mem_ready !== emr) begin bad++; $display("FAIL mem_ready: got %b, required %b (cnt %0d)", bus.mem_ready, emr, m_cnt); end
        if (bus.count !== 3'(m_cnt)) begin bad++; $display("FAIL count: got %0d, required %0d", bus.count, m_cnt); end
        if (bus.empty !== (m_cnt == 0)) begin bad++; $display("FAIL empty: got %b, required %b", bus.empty, m_cnt == 0); end
        np = 0;
        if (mv && emr && ma != '0) begin sb.push_back('{addr: ma, data: md}); np++; end
        if (av && ear && aa != '0) begin sb.push_back('{addr: aa, data: ad}); np++; end
        m_cnt = m_cnt + np - (m_cnt > 0 ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (sb.size() != 0 || m_cnt != 0); i++) idle();
        idle();
        total++;
        if (sb.size() != 0 || bus.count !== '0) begin
            bad++;
            $display("FAIL drain: got %0d writes missing, count=%0d, required 0/0", sb.size(), bus.count);
        end
    endtask

    task automatic check_out(input string nm, input logic we, input raddr_t a, input reg_t d);
        total++;
        if (bus.we !== we || bus.waddr !== a || bus.wdata !== d) begin
            bad++;
            $display("FAIL %s: got we=%b r%0d=%h, required we=%b r%0d=%h", nm, bus.we, bus.waddr, bus.wdata, we, a, d);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_out("reset_out", 1'b0, '0, '0);
        total += 3;
        if (bus.count !== '0 || bus.empty !== 1'b1) begin bad++; $display("FAIL reset_cnt: got count=%0d empty=%b, required 0/1", bus.count, bus.empty); end
        if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready: got %b, required 1", bus.alu_ready); end
        if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL reset_mem_ready: got %b, required 1", bus.mem_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        check_out("single_lat1", 1'b0, '0, '0);
        idle();
        check_out("single_write", 1'b1, 5'd3, 32'h11);
        idle();
        check_out("single_after", 1'b0, '0, '0);
        drain();
    endtask

    task automatic test_dual();
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        total++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin bad++; $display("FAIL dual_ready: got %b%b, required 11", bus.alu_ready, bus.mem_ready); end
        step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
        idle();
        check_out("dual_first", 1'b1, 5'd2, 32'hB);
        idle();
        check_out("dual_second", 1'b1, 5'd1, 32'hA);
        drain();
    endtask

    task automatic test_arb();
        step(1'b1, 5'd4, 32'h40, 1'b1, 5'd5, 32'h50);
        step(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        total++;
        if (bus.count !== 3'd3 || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            bad++;
            $display("FAIL arb_one_slot: got count=%0d ready=%b%b, required 3/10", bus.count, bus.alu_ready, bus.mem_ready);
        end
        step(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h90);
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h90);
        drain();
    endtask

    task automatic test_zero();
        bus.alu_valid = 1'b1; bus.alu_waddr = '0;
        #1;
        total++;
        if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready: got %b, required 1", bus.alu_ready); end
        step(1'b1, '0, 32'hFF, 1'b0, '0, '0);
        total++;
        if (bus.count !== '0) begin bad++; $display("FAIL zero_count: got %0d, required 0", bus.count); end
        idle();
        check_out("zero_nowrite", 1'b0, '0, '0);
        drain();
    endtask

    task automatic test_mid_reset();
        step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
        step(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
        total++;
        if (bus.count !== 3'd3) begin bad++; $display("FAIL pre_reset_count: got %0d, required 3", bus.count); end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        m_cnt = 0;
        check_out("mid_reset_out", 1'b0, '0, '0);
        total++;
        if (bus.count !== '0 || bus.empty !== 1'b1) begin bad++; $display("FAIL mid_reset_cnt: got count=%0d empty=%b, required 0/1", bus.count, bus.empty); end
        repeat (4) idle();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        drain();
    endtask

`ifdef WBQ_BYPASS_EN
    task automatic check_byp(input string nm, input raddr_t ra, input logic hit, input reg_t d);
        bus.byp_raddr = ra;
        #1;
        total++;
        if (bus.byp_hit !== hit || bus.byp_data !== d) begin
            bad++;
            $display("FAIL %s: got hit=%b data=%h, required hit=%b data=%h", nm, bus.byp_hit, bus.byp_data, hit, d);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 5'd5, 32'h1, 1'b0, '0, '0);
        step(1'b1, 5'd5, 32'h2, 1'b0, '0, '0);
        check_byp("byp_young", 5'd5, 1'b1, 32'h2);
        check_byp("byp_r0", 5'd0, 1'b0, '0);
        check_byp("byp_miss", 5'd6, 1'b0, '0);
        idle();
        check_byp("byp_outreg", 5'd5, 1'b1, 32'h2);
        idle();
        check_byp("byp_gone", 5'd5, 1'b0, '0);
        bus.byp_raddr = '0;
        drain();
    endtask
`endif

    initial begin
        bus.alu_valid = 1'b0; bus.alu_waddr = '0; bus.alu_wdata = '0;
        bus.mem_valid = 1'b0; bus.mem_waddr = '0; bus.mem_wdata = '0;
`ifdef WBQ_BYPASS_EN
        bus.byp_raddr = '0;
`endif
        test_reset();
        test_single();
        test_dual();
        test_arb();
        test_zero();
        test_mid_reset();
        test_back_to_back();
`ifdef WBQ_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1);
    end
endmodule
